axi4_lite_master_bridge: RTL and testbench

- Converts the RV32IM core's simple request/ready data-memory port into single-outstanding AXI4-Lite master transactions toward the interconnect.
- Pre-decodes each address against SLAVE_BASE_ADDR/SLAVE_ADDR_MASK from axi4_lite_addr_map_package. Unmapped accesses complete locally with an error and never reach the bus.

---
 rtl/axi4_lite_master_bridge.sv | 189 ++++++++++++++++++
 tb/tb_axi4_lite_master_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_bridge.sv
// Core data-port to AXI4-Lite master bridge, one transaction in flight.
// Unmapped addresses are answered locally with an error.
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   cpu_req/we/addr/wdata/wstrb
//                     core request, held until cpu_ready
//   cpu_ready/rdata/err
//                     one-cycle completion with result
//   m_aw*, m_w*, m_b* AXI4-Lite write channels
//   m_ar*, m_r*       AXI4-Lite read channels

package axi4_lite_addr_map_package;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int SLAVE_NUM  = 2;

    // Entry 0: 0x000-0x0FF, entry 1: 0x100-0x1FF.
    localparam logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]
        SLAVE_BASE_ADDR = {32'h0000_0100, 32'h0000_0000};

    localparam logic [SLAVE_NUM-1:0][ADDR_WIDTH-1:0]
        SLAVE_ADDR_MASK = {32'hFFFF_FF00, 32'hFFFF_FF00};

endpackage

module axi4_lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [STRB_WIDTH-1:0] cpu_wstrb,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_err,

    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,

    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    localparam int SLV_N =
        axi4_lite_addr_map_package::SLAVE_NUM;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] WR_REQ  = 3'd1;
    localparam logic [2:0] WR_RESP = 3'd2;
    localparam logic [2:0] RD_ADDR = 3'd3;
    localparam logic [2:0] RD_DATA = 3'd4;
    localparam logic [2:0] DONE    = 3'd5;
    localparam logic [2:0] ERR     = 3'd6;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            resp_q;
    logic                  aw_done;
    logic                  w_done;

    logic                  addr_hit;
    logic                  aw_fire;
    logic                  w_fire;
    logic                  aw_ok;
    logic                  w_ok;

    // Overlapping entries only matter as hit/miss,
    // so a plain OR over all entries is enough.
    always_comb begin
        addr_hit = 1'b0;
        for (int i = 0; i < SLV_N; i++) begin
            if ((cpu_addr &
                 axi4_lite_addr_map_package::SLAVE_ADDR_MASK[i]) ==
                axi4_lite_addr_map_package::SLAVE_BASE_ADDR[i])
                addr_hit = 1'b1;
        end
    end

    // Valid/ready outputs decode from registered state
    // and flags only; AXI inputs never reach them.
    assign m_awvalid = (state == WR_REQ) && !aw_done;
    assign m_wvalid  = (state == WR_REQ) && !w_done;
    assign m_bready  = (state == WR_RESP);
    assign m_arvalid = (state == RD_ADDR);
    assign m_rready  = (state == RD_DATA);

    assign m_awaddr  = addr_q;
    assign m_araddr  = addr_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;

    assign aw_fire   = m_awvalid && m_awready;
    assign w_fire    = m_wvalid && m_wready;
    assign aw_ok     = aw_done || aw_fire;
    assign w_ok      = w_done || w_fire;

    assign cpu_ready = (state == DONE) || (state == ERR);
    assign cpu_err   = (state == ERR) ||
                       ((state == DONE) && (resp_q != 2'b00));
    assign cpu_rdata = ((state == DONE) && !we_q) ?
                       rdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
            resp_q  <= 2'b00;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req) begin
                        addr_q  <= cpu_addr;
                        we_q    <= cpu_we;
                        wdata_q <= cpu_wdata;
                        wstrb_q <= cpu_wstrb;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        if (!addr_hit)
                            state <= ERR;
                        else if (cpu_we)
                            state <= WR_REQ;
                        else
                            state <= RD_ADDR;
                    end
                end
                WR_REQ: begin
                    if (aw_fire)
                        aw_done <= 1'b1;
                    if (w_fire)
                        w_done <= 1'b1;
                    if (aw_ok && w_ok)
                        state <= WR_RESP;
                end
                WR_RESP: begin
                    if (m_bvalid) begin
                        resp_q <= m_bresp;
                        state  <= DONE;
                    end
                end
                RD_ADDR: begin
                    if (m_arready)
                        state <= RD_DATA;
                end
                RD_DATA: begin
                    if (m_rvalid) begin
                        rdata_q <= m_rdata;
                        resp_q  <= m_rresp;
                        state   <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master_bridge.sv
// Randomized bench for axi4_lite_master_bridge with
// a memory-backed AXI slave and a transaction-level model.

module tb_axi4_lite_master_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_wstrb;
    logic        cpu_ready;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic [1:0]  m_bresp;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] m_araddr;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] m_rdata;
    logic [1:0]  m_rresp;
    logic        m_rvalid;
    logic        m_rready;

    always #5 clk = ~clk;

    axi4_lite_master_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid),
        .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bresp(m_bresp),
        .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid),
        .m_arready(m_arready), .m_rdata(m_rdata),
        .m_rresp(m_rresp), .m_rvalid(m_rvalid),
        .m_rready(m_rready)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // Slave configuration for the current transaction.
    int         cfg_aw_dly, cfg_w_dly, cfg_b_dly;
    int         cfg_ar_dly, cfg_r_dly;
    logic [1:0] cfg_resp;

    // Slave state and bus monitors.
    logic [31:0] smem [128];
    logic [31:0] ref_mem [128];
    int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
    bit aw_got, w_got, b_pend, r_pend;
    bit b_drop, r_drop;
    int aw_hs = 0, w_hs = 0, ar_hs = 0;
    int aw_vcyc = 0, w_vcyc = 0, ar_vcyc = 0;
    int bready_early = 0;
    logic [31:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [3:0]  cap_wstrb;

    initial begin
        bit new_pair;
        m_awready = 0; m_wready = 0; m_arready = 0;
        m_bvalid = 0; m_bresp = 0;
        m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_awready = 0; m_wready = 0;
                m_arready = 0; m_bvalid = 0;
                m_rvalid = 0; m_bresp = 0;
                m_rresp = 0; m_rdata = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0;
                b_pend = 0; r_pend = 0;
                b_drop = 0; r_drop = 0;
            end else begin
                if (m_bready && !(aw_got && w_got))
                    bready_early++;
                if (m_awvalid) aw_vcyc++;
                if (m_wvalid)  w_vcyc++;
                if (m_arvalid) ar_vcyc++;
                if (b_drop) begin
                    m_bvalid = 0; b_drop = 0;
                end
                if (r_drop) begin
                    m_rvalid = 0; r_drop = 0;
                end
                if (b_pend) begin
                    if (b_cnt >= cfg_b_dly) begin
                        m_bvalid = 1;
                        m_bresp  = cfg_resp;
                        b_pend   = 0;
                    end else b_cnt++;
                end
                if (r_pend) begin
                    if (r_cnt >= cfg_r_dly) begin
                        m_rvalid = 1;
                        m_rdata  = smem[cap_araddr[8:2]];
                        m_rresp  = cfg_resp;
                        r_pend   = 0;
                    end else r_cnt++;
                end
                new_pair = 0;
                m_awready = 0;
                if (m_awvalid && !aw_got) begin
                    if (aw_cnt >= cfg_aw_dly) begin
                        m_awready  = 1;
                        aw_got     = 1;
                        aw_hs++;
                        cap_awaddr = m_awaddr;
                        aw_cnt     = 0;
                        new_pair   = 1;
                    end else aw_cnt++;
                end
                m_wready = 0;
                if (m_wvalid && !w_got) begin
                    if (w_cnt >= cfg_w_dly) begin
                        m_wready  = 1;
                        w_got     = 1;
                        w_hs++;
                        cap_wdata = m_wdata;
                        cap_wstrb = m_wstrb;
                        w_cnt     = 0;
                        new_pair  = 1;
                    end else w_cnt++;
                end
                if (new_pair && aw_got && w_got) begin
                    for (int b = 0; b < 4; b++)
                        if (cap_wstrb[b])
                            smem[cap_awaddr[8:2]][b*8 +: 8] =
                                cap_wdata[b*8 +: 8];
                    b_pend = 1;
                    b_cnt  = 0;
                end
                m_arready = 0;
                if (m_arvalid) begin
                    if (ar_cnt >= cfg_ar_dly) begin
                        m_arready  = 1;
                        ar_hs++;
                        cap_araddr = m_araddr;
                        r_pend     = 1;
                        r_cnt      = 0;
                        ar_cnt     = 0;
                    end else ar_cnt++;
                end
                if (m_bvalid && m_bready) begin
                    b_drop = 1;
                    aw_got = 0;
                    w_got  = 0;
                end
                if (m_rvalid && m_rready)
                    r_drop = 1;
            end
        end
    end

    // One CPU transaction, starting and ending on a negedge.
    // The caller must present the next request or drop
    // cpu_req immediately after return.
    task automatic do_txn(input bit we,
                          input logic [31:0] addr,
                          input logic [31:0] wdata,
                          input logic [3:0] wstrb,
                          input int ad, input int wd,
                          input int bd, input int ard,
                          input int rd,
                          input logic [1:0] resp);
        bit          mapped, seen;
        int          exp_lat, cyc;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          aw0, w0, ar0, awv0, wv0, arv0, be0;
        mapped = (addr < 32'h200);
        cfg_aw_dly = ad; cfg_w_dly = wd; cfg_b_dly = bd;
        cfg_ar_dly = ard; cfg_r_dly = rd; cfg_resp = resp;
        exp_rdata = 32'h0;
        if (!mapped) begin
            exp_lat = 1;
            exp_err = 1'b1;
        end else if (we) begin
            exp_lat = 3 + ((ad > wd) ? ad : wd) + bd;
            exp_err = (resp != 2'b00);
            for (int b = 0; b < 4; b++)
                if (wstrb[b])
                    ref_mem[addr[8:2]][b*8 +: 8] =
                        wdata[b*8 +: 8];
        end else begin
            exp_lat   = 3 + ard + rd;
            exp_err   = (resp != 2'b00);
            exp_rdata = ref_mem[addr[8:2]];
        end
        aw0 = aw_hs; w0 = w_hs; ar0 = ar_hs;
        awv0 = aw_vcyc; wv0 = w_vcyc; arv0 = ar_vcyc;
        be0 = bready_early;
        cpu_req = 1; cpu_we = we; cpu_addr = addr;
        cpu_wdata = wdata; cpu_wstrb = wstrb;
        cyc = 0; seen = 0;
        while (!seen && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (cpu_ready) seen = 1;
        end
        check("ready_seen", 64'(seen), 64'd1);
        if (seen) begin
            check("latency", 64'(cyc), 64'(exp_lat));
            check("err", 64'(cpu_err), 64'(exp_err));
            check("rdata", 64'(cpu_rdata), 64'(exp_rdata));
        end
        @(negedge clk);
        check("ready_pulse", 64'(cpu_ready), 64'd0);
        if (!mapped) begin
            check("no_bus", 64'((aw_vcyc - awv0) +
                  (w_vcyc - wv0) + (ar_vcyc - arv0)), 64'd0);
        end else if (we) begin
            check("aw_hs", 64'(aw_hs - aw0), 64'd1);
            check("w_hs", 64'(w_hs - w0), 64'd1);
            check("awaddr", 64'(cap_awaddr), 64'(addr));
            check("wdata", 64'(cap_wdata), 64'(wdata));
            check("wstrb", 64'(cap_wstrb), 64'(wstrb));
            check("aw_cycles", 64'(aw_vcyc - awv0),
                  64'(ad + 1));
            check("w_cycles", 64'(w_vcyc - wv0),
                  64'(wd + 1));
            check("bready_early",
                  64'(bready_early - be0), 64'd0);
        end else begin
            check("ar_hs", 64'(ar_hs - ar0), 64'd1);
            check("araddr", 64'(cap_araddr), 64'(addr));
            check("ar_cycles", 64'(ar_vcyc - arv0),
                  64'(ard + 1));
        end
    endtask

    initial begin
        int          cyc;
        bit          we;
        logic [31:0] addr;
        logic [1:0]  resp;
        int          ad, wd, bd, ard, rd;

        for (int i = 0; i < 128; i++) begin
            smem[i]    = $urandom;
            ref_mem[i] = smem[i];
        end
        smem[65]    = 32'hDEAD_BEEF;
        ref_mem[65] = 32'hDEAD_BEEF;

        rst_n = 0; cpu_req = 0; cpu_we = 0;
        cpu_addr = 0; cpu_wdata = 0; cpu_wstrb = 0;
        cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0;
        cfg_ar_dly = 0; cfg_r_dly = 0; cfg_resp = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", 64'({cpu_ready, cpu_err,
              m_awvalid, m_wvalid, m_bready,
              m_arvalid, m_rready}), 64'd0);
        check("reset_addr", {m_awaddr, m_araddr}, 64'd0);
        check("reset_data", {m_wdata, cpu_rdata}, 64'd0);
        check("reset_strb", 64'(m_wstrb), 64'd0);
        rst_n = 1;
        @(negedge clk);

        do_txn(0, 32'h104, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_txn(1, 32'h010, 32'h1234_5678, 4'hF,
               2, 0, 0, 0, 0, 2'b00);
        do_txn(0, 32'h200, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_txn(1, 32'h108, 32'hA5A5_5A5A, 4'h3,
               0, 1, 1, 0, 0, 2'b10);
        do_txn(0, 32'h104, 0, 0, 0, 0, 0, 0, 1, 2'b11);
        do_txn(1, 32'h0FC, 32'hFFFF_FFFF, 4'h0,
               1, 2, 0, 0, 0, 2'b00);
        cpu_req = 0;
        @(negedge clk);

        cfg_ar_dly = 0; cfg_r_dly = 6; cfg_resp = 0;
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'h104;
        cyc = 0;
        while (!m_rready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("rd_data_reached", 64'(m_rready), 64'd1);
        #2 rst_n = 0;
        #1;
        check("rst_async", 64'({m_rready, m_arvalid,
              cpu_ready, m_awvalid, m_wvalid,
              m_bready}), 64'd0);
        check("rst_regs", {m_araddr, cpu_rdata}, 64'd0);
        cpu_req = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_txn(0, 32'h000, 0, 0, 0, 0, 0, 0, 0, 2'b00);

        do_txn(1, 32'h100, 32'hCAFE_F00D, 4'hF,
               0, 0, 0, 0, 0, 2'b00);
        do_txn(0, 32'h100, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_txn(0, 32'h300, 0, 0, 0, 0, 0, 0, 0, 2'b00);
        do_txn(1, 32'h000, 32'h0BAD_C0DE, 4'h5,
               0, 0, 0, 0, 0, 2'b00);
        cpu_req = 0;
        @(negedge clk);

        for (int n = 0; n < 60; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0)
                addr[31] = 1'b1;
            resp = ($urandom_range(0, 3) == 0) ?
                   2'($urandom_range(1, 3)) : 2'b00;
            ad  = $urandom_range(0, 3);
            wd  = $urandom_range(0, 3);
            bd  = $urandom_range(0, 3);
            ard = $urandom_range(0, 3);
            rd  = $urandom_range(0, 3);
            do_txn(we, addr, $urandom, 4'($urandom),
                   ad, wd, bd, ard, rd, resp);
            if ($urandom_range(0, 3) == 0) begin
                cpu_req = 0;
                @(negedge clk);
            end
        end
        cpu_req = 0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
